// File: rtl/led_chaser_if.sv
// Pattern-control bundle for led_chaser: enable/mode/direction in, LED pattern and pulses out.
interface led_chaser_if #(
   parameter int unsigned WIDTH = 8
);
   logic             en;
   logic [1:0]       mode;
   logic             dir;
   logic [WIDTH-1:0] q;
   logic             step;
   logic             wrap;

   modport master (output en, mode, dir, input q, step, wrap);
   modport slave  (input en, mode, dir, output q, step, wrap);
endinterface

// File: rtl/led_chaser.sv
// LED pattern generator: prescaled stepping through Johnson, dot-ring, bounce and binary patterns.
module led_chaser #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIV   = 4
) (
   input logic           clk,
   input logic           rs,
   led_chaser_if.slave   bus
);
   typedef enum logic [1:0] {ModeJohnson, ModeDot, ModeBounce, ModeCount} mode_e;

   localparam int unsigned    CntW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

   logic [WIDTH-1:0] q_q, q_d, stepped;
   logic [CntW-1:0]  cnt_q, cnt_d;
   mode_e            mode_q, mode_d, mode_in;
   logic             up_q, up_d, up_next;
   logic             step_q, step_d, wrap_q, wrap_d;
   logic             tick;

   function automatic logic [WIDTH-1:0] start_state(mode_e m, logic d);
      logic [WIDTH-1:0] s;
      s = '0;
      if (m == ModeDot) begin
         s = d ? {1'b1, {(WIDTH-1){1'b0}}} : {{(WIDTH-1){1'b0}}, 1'b1};
      end else if (m == ModeBounce) begin
         s = {{(WIDTH-1){1'b0}}, 1'b1};
      end
      return s;
   endfunction

   assign mode_in = mode_e'(bus.mode);
   assign tick    = bus.en && (cnt_q == CntMax);

   always_comb begin
      stepped = q_q;
      up_next = up_q;
      unique case (mode_q)
         ModeJohnson: stepped = bus.dir ? {~q_q[0], q_q[WIDTH-1:1]}
                                        : {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
         ModeDot: begin
            if (q_q == '0) stepped = start_state(ModeDot, bus.dir);
            else           stepped = bus.dir ? {q_q[0], q_q[WIDTH-1:1]}
                                             : {q_q[WIDTH-2:0], q_q[WIDTH-1]};
         end
         ModeBounce: begin
            stepped = up_q ? (q_q << 1) : (q_q >> 1);
            // Reverse as soon as the dot lands on an end bit.
            if (stepped[WIDTH-1])  up_next = 1'b0;
            else if (stepped[0])   up_next = 1'b1;
         end
         ModeCount: stepped = bus.dir ? (q_q - 1'b1) : (q_q + 1'b1);
         default: stepped = q_q;
      endcase
   end

   always_comb begin
      q_d    = q_q;
      cnt_d  = cnt_q;
      mode_d = mode_q;
      up_d   = up_q;
      step_d = 1'b0;
      wrap_d = 1'b0;
      if (mode_in != mode_q) begin
         q_d    = start_state(mode_in, bus.dir);
         cnt_d  = '0;
         mode_d = mode_in;
         up_d   = 1'b1;
      end else if (tick) begin
         q_d    = stepped;
         cnt_d  = '0;
         up_d   = up_next;
         step_d = 1'b1;
         wrap_d = (stepped == start_state(mode_q, bus.dir));
      end else if (bus.en) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rs) begin
      if (rs) begin
         q_q    <= '0;
         cnt_q  <= '0;
         mode_q <= ModeJohnson;
         up_q   <= 1'b1;
         step_q <= 1'b0;
         wrap_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         cnt_q  <= cnt_d;
         mode_q <= mode_d;
         up_q   <= up_d;
         step_q <= step_d;
         wrap_q <= wrap_d;
      end
   end

   assign bus.q    = q_q;
   assign bus.step = step_q;
   assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_led_chaser.sv
// Self-checking bench: DIV=1 and DIV=4 instances share stimulus and are compared to a pattern model.
module tb_led_chaser;
   localparam int W = 8;

   logic       clk = 1'b0;
   logic       rs;
   logic       en;
   logic [1:0] mode;
   logic       dir;
   int         vectors = 0;
   int         miscompares = 0;

   always #5 clk = ~clk;

   led_chaser_if #(.WIDTH(W)) bus1 ();
   led_chaser_if #(.WIDTH(W)) bus4 ();

   assign bus1.en = en;
   assign bus1.mode = mode;
   assign bus1.dir = dir;
   assign bus4.en = en;
   assign bus4.mode = mode;
   assign bus4.dir = dir;

   led_chaser #(.WIDTH(W), .DIV(1)) u1 (.clk(clk), .rs(rs), .bus(bus1));
   led_chaser #(.WIDTH(W), .DIV(4)) u4 (.clk(clk), .rs(rs), .bus(bus4));

   // Model state per instance: [0] is DIV=1, [1] is DIV=4.
   int mq[2], mcnt[2], mmode[2], mup[2], mstep[2], mwrap[2];
   int divs[2] = '{1, 4};
   int mask = (1 << W) - 1;

   function automatic int start_of(int m, logic d);
      case (m)
         1:       return d ? (1 << (W - 1)) : 1;
         2:       return 1;
         default: return 0;
      endcase
   endfunction

   function automatic int next_of(int m, logic d, int q, inout int up);
      int pos;
      case (m)
         0: begin
            if (!d) return ((q << 1) & mask) | (1 - ((q >> (W - 1)) & 1));
            else    return (q >> 1) | ((1 - (q & 1)) << (W - 1));
         end
         1: begin
            if (q == 0) return start_of(1, d);
            if (!d) return ((q << 1) | (q >> (W - 1))) & mask;
            else    return (q >> 1) | ((q & 1) << (W - 1));
         end
         2: begin
            pos = 0;
            for (int p = 0; p < W; p++) if (q == (1 << p)) pos = p;
            pos = up ? pos + 1 : pos - 1;
            if (pos == W - 1) up = 0;
            else if (pos == 0) up = 1;
            return 1 << pos;
         end
         default: return d ? (q + mask) & mask : (q + 1) & mask;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         mq[i] = 0; mcnt[i] = 0; mmode[i] = 0; mup[i] = 1; mstep[i] = 0; mwrap[i] = 0;
      end
   endtask

   task automatic model_edge();
      int upv;
      for (int i = 0; i < 2; i++) begin
         mstep[i] = 0;
         mwrap[i] = 0;
         if (int'(mode) != mmode[i]) begin
            mmode[i] = int'(mode);
            mq[i] = start_of(mmode[i], dir);
            mcnt[i] = 0;
            mup[i] = 1;
         end else if (en) begin
            if (mcnt[i] == divs[i] - 1) begin
               mcnt[i] = 0;
               upv = mup[i];
               mq[i] = next_of(mmode[i], dir, mq[i], upv);
               mup[i] = upv;
               mstep[i] = 1;
               mwrap[i] = (mq[i] == start_of(mmode[i], dir)) ? 1 : 0;
            end else begin
               mcnt[i]++;
            end
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("u1_q", 32'(bus1.q), mq[0]);
      chk("u1_step", 32'(bus1.step), mstep[0]);
      chk("u1_wrap", 32'(bus1.wrap), mwrap[0]);
      chk("u4_q", 32'(bus4.q), mq[1]);
      chk("u4_step", 32'(bus4.step), mstep[1]);
      chk("u4_wrap", 32'(bus4.wrap), mwrap[1]);
   endtask

   task automatic cycle();
      @(posedge clk);
      if (rs) model_reset();
      else    model_edge();
      #1;
      check_all();
   endtask

   task automatic reset_pulse();
      rs = 1'b1;
      cycle();
      rs = 1'b0;
   endtask

   logic [7:0] johnson_tbl [16] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                                    8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
   logic [7:0] dot_tbl [8] = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};

   initial begin
      rs = 1'b1; en = 1'b0; mode = 2'd0; dir = 1'b0;
      model_reset();
      #1;
      check_all();
      chk("rst_q", 32'(bus1.q), 0);
      repeat (2) cycle();
      rs = 1'b0;

      // Johnson fill/drain
      en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         cycle();
         chk("johnson_q", 32'(bus1.q), 32'(johnson_tbl[i]));
         chk("johnson_wrap", 32'(bus1.wrap), (i == 15) ? 1 : 0);
      end
      repeat (6) cycle();
      chk("pre_rst_q", 32'(bus1.q), 32'h3F);

      // Asynchronous reset between edges
      #2 rs = 1'b1;
      #1;
      model_reset();
      chk("async_q", 32'(bus1.q), 0);
      chk("async_step", 32'(bus1.step), 0);
      chk("async_wrap", 32'(bus1.wrap), 0);
      check_all();
      cycle();
      rs = 1'b0;

      // Single-dot ring, toward LSB
      mode = 2'd1; dir = 1'b1;
      cycle();
      chk("dot_load_q", 32'(bus1.q), 32'h80);
      chk("dot_load_step", 32'(bus1.step), 0);
      for (int i = 0; i < 8; i++) begin
         cycle();
         chk("dot_q", 32'(bus1.q), 32'(dot_tbl[i]));
         chk("dot_wrap", 32'(bus1.wrap), (i == 7) ? 1 : 0);
      end

      // Bounce ignores dir
      mode = 2'd2;
      cycle();
      chk("bounce_load_q", 32'(bus1.q), 1);
      for (int i = 0; i < 14; i++) begin
         dir = 1'($urandom_range(0, 1));
         cycle();
         chk("bounce_q", 32'(bus1.q), 1 << ((i < 7) ? i + 1 : 13 - i));
         chk("bounce_wrap", 32'(bus1.wrap), (i == 13) ? 1 : 0);
      end

      // Count down, then mode switch takes priority over a pending tick on u4
      mode = 2'd3; dir = 1'b1;
      reset_pulse();
      cycle();
      chk("cnt_load_q", 32'(bus1.q), 0);
      chk("cnt_load_step", 32'(bus1.step), 0);
      cycle(); chk("cnt_ff", 32'(bus1.q), 32'hFF);
      cycle(); chk("cnt_fe", 32'(bus1.q), 32'hFE);
      cycle(); chk("cnt_fd", 32'(bus1.q), 32'hFD);
      mode = 2'd0;
      cycle();
      chk("switch_q", 32'(bus1.q), 0);
      chk("switch_step", 32'(bus1.step), 0);
      chk("switch_u4_step", 32'(bus4.step), 0);
      for (int k = 0; k < 4; k++) begin
         cycle();
         chk("switch_u4_cnt", 32'(bus4.step), (k == 3) ? 1 : 0);
      end

      // DIV=4 prescaler with an enable stall
      dir = 1'b0;
      reset_pulse();
      for (int k = 0; k < 4; k++) begin
         cycle();
         chk("div4_step", 32'(bus4.step), (k == 3) ? 1 : 0);
      end
      repeat (2) cycle();
      en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cycle();
         chk("stall_q", 32'(bus4.q), 1);
         chk("stall_step", 32'(bus4.step), 0);
      end
      en = 1'b1;
      cycle(); chk("resume_step0", 32'(bus4.step), 0);
      cycle(); chk("resume_step1", 32'(bus4.step), 1);
      chk("resume_q", 32'(bus4.q), 32'h03);

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         en = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) dir = ~dir;
         if ($urandom_range(0, 63) == 0) begin
            #2 rs = 1'b1;
            #1;
            model_reset();
            check_all();
            cycle();
            rs = 1'b0;
         end else begin
            cycle();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/led_chaser.md
LED_CHASER -- requirements
Module: led_chaser

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of pattern bits; legal range is 2 or more.
REQ-002 The block SHALL have parameter DIV, default 4, giving the number of enabled clock cycles per pattern step; legal range is 1 or more.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rs  input  1  reset; asynchronous, active-high.
REQ-005 en  input  1  advance enable; 0 freezes the prescaler and the pattern.
REQ-006 mode  input  2  pattern select: 0 = Johnson fill/drain, 1 = single-dot ring, 2 = bounce, 3 = binary count.
REQ-007 dir  input  1  direction: 0 = toward the MSB / count up; 1 = toward the LSB / count down.
REQ-008 q  output  WIDTH  registered pattern, drives the LEDs.
REQ-009 step  output  1  registered one-cycle pulse, asserted in the cycle q takes a stepped value.
REQ-010 wrap  output  1  registered one-cycle pulse, asserted with step when the stepped q equals the start state of the current mode.

Function
REQ-011 Prescaler cnt SHALL run 0..DIV-1, incrementing only when en=1; tick = en AND cnt==DIV-1; on tick, cnt returns to 0.
REQ-012 When DIV=1, tick SHALL equal en, so the pattern steps every enabled cycle.
REQ-013 The block SHALL update q only on tick or on a mode load; otherwise q holds.
REQ-014 Start states SHALL be:
- mode 0: all zero
- mode 1: 1 in bit 0 if dir=0, 1 in bit WIDTH-1 if dir=1
- mode 2: 1 in bit 0, bounce direction = up
- mode 3: all zero
REQ-015 Mode 0 step SHALL be:
- dir=0: q <= {q[WIDTH-2:0], ~q[WIDTH-1]}
- dir=1: q <= {~q[0], q[WIDTH-1:1]}
- period 2*WIDTH steps
REQ-016 Mode 1 step SHALL rotate left (dir=0) or right (dir=1) by one bit; if q is 0 at a tick, it SHALL load the mode-1 start state instead.
REQ-017 Mode 2 SHALL keep an internal bounce-direction bit and step as follows:
- moves a single dot one position per tick in the bounce direction
- the dot reverses on reaching bit WIDTH-1 or bit 0
- period 2*WIDTH-2 steps
- dir is ignored
REQ-018 Mode 3 step SHALL add 1 (dir=0) or subtract 1 (dir=1) modulo 2^WIDTH.
REQ-019 A dir change in modes 0, 1 and 3 SHALL take effect at the next tick without reloading q.
REQ-020 The block SHALL register the mode in mode_q.
REQ-021 Mode load: when mode != mode_q, on the next edge the block SHALL:
- load q with the new mode's start state
- clear cnt
- set mode_q = mode
- drive step = 0 and wrap = 0
- mode load takes priority over tick
REQ-022 step and wrap SHALL be 0 in every cycle that is not a tick-driven update.
REQ-023 en=0 SHALL hold cnt, q and the bounce-direction bit, and SHALL force step = 0 and wrap = 0 on the next edge.

Reset
REQ-024 While rs=1, the block SHALL asynchronously force:
- q = 0, cnt = 0, mode_q = 0
- bounce direction = up
- step = 0, wrap = 0
REQ-025 After rs falls, a mode input other than 0 SHALL trigger the REQ-021 mode load on the first clock edge.
REQ-026 Asserting rs mid-pattern SHALL take effect immediately, without waiting for a clock edge.

Verification (WIDTH=8, DIV=1 unless stated)
REQ-027 Mode 0, dir=0, en=1 after reset -> q = 01, 03, 07, 0F, 1F, 3F, 7F, FF, FE, FC, F8, F0, E0, C0, 80, 00; wrap=1 only on the 00 step.
REQ-028 Mode 1, dir=1 after reset -> q 00 -> 80 (load, step=0), then 40, 20, 10, 08, 04, 02, 01, 80 (wrap=1).
REQ-029 Mode 2 -> q 01, 02, 04, ..., 80, 40, ..., 02, 01; wrap=1 on the return to 01 after 14 steps; toggling dir has no effect.
REQ-030 DIV=4, mode 0 -> step every 4th cycle; en low for 3 cycles mid-count -> q and cnt frozen; stepping resumes with the remaining count.
REQ-031 Mode 3, dir=1 from reset -> q FF, FE, FD; switching mode to 0 at q=FD -> next edge q=00, step=0, cnt=0.
REQ-032 rs pulse between clock edges with q=3F in mode 0 -> q=00, step=0, wrap=0 before the next edge.
